// File: rtl/pdm_capture_ctrl_if.sv
// Signal bundle between pdm_capture_ctrl, the PDM deserializer and the sample RAM write port.
// master = capture controller side, slave = deserializer/RAM side.
interface pdm_capture_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic                  mic_en;
  logic                  mic_data_ready;
  logic [DATA_WIDTH-1:0] mic_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  modport master (
    output mic_en, mem_we, mem_addr, mem_wdata,
    input  mic_data_ready, mic_data
  );

  modport slave (
    input  mic_en, mem_we, mem_addr, mem_wdata,
    output mic_data_ready, mic_data
  );
endinterface

// File: rtl/pdm_capture_ctrl.sv
// Recording-session sequencer: enables the PDM deserializer, drops warm-up samples, writes samples to RAM.
// Optional feature macro PDM_CAPTURE_PEAK_EN adds the unsigned running-maximum output 'peak'.
module pdm_capture_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 12,
  parameter int DEPTH          = 4096,
  parameter int WARMUP_SAMPLES = 1024
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  circular,
  pdm_capture_ctrl_if.master    bus,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped,
  output logic [ADDR_WIDTH:0]   sample_count
`ifdef PDM_CAPTURE_PEAK_EN
  ,
  output logic [DATA_WIDTH-1:0] peak
`endif
);

  localparam int WU_W = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
  localparam logic [WU_W-1:0]       WU_LAST  = (WARMUP_SAMPLES > 0) ? WU_W'(WARMUP_SAMPLES - 1) : '0;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_MAX  = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WARMUP,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                state;
  logic                  rdy_q;
  logic                  circ_q;
  logic [WU_W-1:0]       wu_cnt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  sample_evt;

  // A held data-ready level is one sample; only its rising edge counts, and only while enabled.
  assign sample_evt = bus.mic_en & bus.mic_data_ready & ~rdy_q;

  // NOTE: all state below is assigned with non-blocking <= so every register samples
  // pre-edge values; blocking = here would make the order of statements change behaviour.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state            <= S_IDLE;
      rdy_q            <= 1'b0;
      circ_q           <= 1'b0;
      wu_cnt           <= '0;
      wr_ptr           <= '0;
      bus.mic_en       <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      wrapped          <= 1'b0;
      sample_count     <= '0;
`ifdef PDM_CAPTURE_PEAK_EN
      peak             <= '0;
`endif
    end else begin
      // NOTE: mem_we defaults low each cycle so a write branch produces a single-cycle strobe.
      bus.mem_we <= 1'b0;
      rdy_q      <= bus.mic_en ? bus.mic_data_ready : 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          // start wins over a simultaneous stop here; a lone stop is ignored.
          if (start) begin
            circ_q       <= circular;
            done         <= 1'b0;
            wrapped      <= 1'b0;
            sample_count <= '0;
            wu_cnt       <= '0;
            wr_ptr       <= '0;
            bus.mic_en   <= 1'b1;
            busy         <= 1'b1;
`ifdef PDM_CAPTURE_PEAK_EN
            peak         <= '0;
`endif
            state        <= (WARMUP_SAMPLES > 0) ? S_WARMUP : S_CAPTURE;
          end
        end

        S_WARMUP: begin
          if (stop) begin
            state      <= S_DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            bus.mic_en <= 1'b0;
          end else if (sample_evt) begin
            wu_cnt <= wu_cnt + 1'b1;
            if (wu_cnt == WU_LAST) state <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          // stop wins: a sample arriving with it is dropped; a strobe already issued still completes.
          if (stop) begin
            state      <= S_DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            bus.mic_en <= 1'b0;
          end else if (sample_evt) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= wr_ptr;
            bus.mem_wdata <= bus.mic_data;
            if (sample_count != CNT_MAX) sample_count <= sample_count + 1'b1;
`ifdef PDM_CAPTURE_PEAK_EN
            if (bus.mic_data > peak) peak <= bus.mic_data;
`endif
            if (wr_ptr == PTR_LAST) begin
              wr_ptr <= '0;
              if (circ_q) begin
                wrapped <= 1'b1;
              end else begin
                // One-shot buffer full: session ends on the same edge as its last strobe.
                state      <= S_DONE;
                done       <= 1'b1;
                busy       <= 1'b0;
                bus.mic_en <= 1'b0;
              end
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Randomised scoreboard bench for pdm_capture_ctrl: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares each mem_we strobe.
module tb_pdm_capture_ctrl;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int WU    = 2;
  localparam int HOLD  = 3;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          circular = 1'b0;
  logic          busy, done, wrapped;
  logic [AW:0]   sample_count;
`ifdef PDM_CAPTURE_PEAK_EN
  logic [DW-1:0] peak;
`endif

  pdm_capture_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pdm_capture_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WARMUP_SAMPLES(WU)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .start        (start),
    .stop         (stop),
    .circular     (circular),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .wrapped      (wrapped),
    .sample_count (sample_count)
`ifdef PDM_CAPTURE_PEAK_EN
    ,
    .peak         (peak)
`endif
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Session-level reference model.
  bit            m_on, m_circ, m_done, m_wrapped;
  int            m_events, m_count;
  logic [DW-1:0] m_peak;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge HCLK);
      if (bus.mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
          check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
        end
      end
    end
  end

  task automatic do_start(input bit circ, input bit with_stop);
    start    = 1'b1;
    circular = circ;
    stop     = with_stop;
    if (!m_on) begin
      m_on = 1; m_circ = circ; m_done = 0; m_wrapped = 0;
      m_events = 0; m_count = 0; m_peak = '0;
    end else if (with_stop) begin
      m_on = 0; m_done = 1;
    end
    @(negedge HCLK);
    start    = 1'b0;
    stop     = 1'b0;
    circular = 1'($urandom);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    if (m_on) begin m_on = 0; m_done = 1; end
    @(negedge HCLK);
    stop = 1'b0;
  endtask

  task automatic send_sample(input logic [DW-1:0] data, input int hold, input bit with_stop);
    int idx;
    bit was_on;
    was_on = m_on;
    bus.mic_data       = data;
    bus.mic_data_ready = 1'b1;
    stop               = with_stop;
    if (with_stop && m_on) begin
      m_on = 0; m_done = 1;
    end else if (m_on) begin
      if (m_events >= WU) begin
        idx = m_events - WU;
        exp_q.push_back('{addr: AW'(idx % DEPTH), data: data});
        m_count = (idx + 1 > DEPTH) ? DEPTH : idx + 1;
        if (data > m_peak) m_peak = data;
        if (idx == DEPTH - 1) begin
          if (m_circ) m_wrapped = 1;
          else begin m_on = 0; m_done = 1; end
        end
      end
      m_events++;
    end
    @(negedge HCLK);
    stop = 1'b0;
    if (with_stop && was_on) check("stop_done_next", 32'(done), 32'd1);
    repeat (hold - 1) @(negedge HCLK);
    bus.mic_data_ready = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge HCLK);
  endtask

  task automatic check_status(input string tag);
    check({tag, ".busy"},         32'(busy),         32'(m_on));
    check({tag, ".mic_en"},       32'(bus.mic_en),   32'(m_on));
    check({tag, ".done"},         32'(done),         32'(m_done));
    check({tag, ".wrapped"},      32'(wrapped),      32'(m_wrapped));
    check({tag, ".sample_count"}, 32'(sample_count), 32'(m_count));
    check({tag, ".pending"},      32'(exp_q.size()), 32'd0);
`ifdef PDM_CAPTURE_PEAK_EN
    check({tag, ".peak"},         32'(peak),         32'(m_peak));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mic_en"},       32'(bus.mic_en),    32'd0);
    check({tag, ".mem_we"},       32'(bus.mem_we),    32'd0);
    check({tag, ".mem_addr"},     32'(bus.mem_addr),  32'd0);
    check({tag, ".mem_wdata"},    32'(bus.mem_wdata), 32'd0);
    check({tag, ".busy"},         32'(busy),          32'd0);
    check({tag, ".done"},         32'(done),          32'd0);
    check({tag, ".wrapped"},      32'(wrapped),       32'd0);
    check({tag, ".sample_count"}, 32'(sample_count),  32'd0);
  endtask

  task automatic warmup_feed();
    repeat (WU) send_sample(DW'($urandom), HOLD, 1'b0);
  endtask

  initial begin
    int n;
    bit c;
    bus.mic_data_ready = 1'b0;
    bus.mic_data       = '0;
    m_on = 0; m_circ = 0; m_done = 0; m_wrapped = 0;
    m_events = 0; m_count = 0; m_peak = '0;

    repeat (3) @(negedge HCLK);
    check_all_zero("reset");
    HRESET = 1'b0;
    @(negedge HCLK);

    // One-shot: 1 and 2 are warm-up, 3..10 land at addresses 0..7.
    do_start(1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) send_sample(DW'(i), HOLD, 1'b0);
    check_status("oneshot");
    check("oneshot.count8", 32'(sample_count), 32'd8);
    do_stop();
    check_status("stop_in_done");

    // Circular: 12 captures wrap once.
    do_start(1'b1, 1'b0);
    warmup_feed();
    for (int i = 0; i < 12; i++) send_sample(DW'($urandom), HOLD, 1'b0);
    do_stop();
    check_status("circular");
    check("circular.wrapped", 32'(wrapped), 32'd1);

    // Stop coincides with the 4th capture event.
    do_start(1'b0, 1'b0);
    warmup_feed();
    for (int i = 0; i < 3; i++) send_sample(DW'($urandom), HOLD, 1'b0);
    send_sample(DW'($urandom), HOLD, 1'b1);
    check_status("stop_mid");
    check("stop_mid.count3", 32'(sample_count), 32'd3);

    // Held ready gives one write; start while busy is ignored; start+stop while busy stops.
    do_start(1'b1, 1'b0);
    warmup_feed();
    send_sample(DW'($urandom), 10, 1'b0);
    check_status("held_ready");
    do_start(1'b0, 1'b0);
    check_status("start_busy");
    send_sample(DW'($urandom), HOLD, 1'b0);
    send_sample(DW'($urandom), HOLD, 1'b0);
    do_start(1'b1, 1'b1);
    check_status("start_stop_busy");

    // start+stop from DONE: start wins.
    do_start(1'b0, 1'b1);
    check_status("start_stop_done");
    warmup_feed();
    for (int i = 0; i < 5; i++) send_sample(DW'($urandom) | 16'h1, HOLD, 1'b0);
    check_status("pre_reset");
    HRESET = 1'b1;
    @(negedge HCLK);
    check_all_zero("mid_reset");
    HRESET = 1'b0;
    m_on = 0; m_done = 0; m_wrapped = 0; m_count = 0; m_peak = '0;
    exp_q.delete();
    @(negedge HCLK);
    do_start(1'b0, 1'b0);
    warmup_feed();
    send_sample(DW'($urandom), HOLD, 1'b0);
    send_sample(DW'($urandom), HOLD, 1'b0);
    do_stop();
    check_status("after_reset");

    // Randomised sessions.
    for (int s = 0; s < 6; s++) begin
      c = 1'($urandom);
      n = $urandom_range(1, 15);
      if (c && n == DEPTH) n = DEPTH + 1;
      do_start(c, 1'b0);
      repeat (WU + n) send_sample(DW'($urandom), $urandom_range(1, 4), 1'b0);
      if (m_on) do_stop();
      check_status("random");
    end

`ifdef PDM_CAPTURE_PEAK_EN
    do_start(1'b0, 1'b0);
    warmup_feed();
    send_sample(16'h0010, HOLD, 1'b0);
    send_sample(16'h8000, HOLD, 1'b0);
    send_sample(16'h0123, HOLD, 1'b0);
    do_stop();
    check("peak_max", 32'(peak), 32'h8000);
    do_start(1'b0, 1'b0);
    check("peak_cleared", 32'(peak), 32'd0);
    do_stop();
`endif

    repeat (3) @(negedge HCLK);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pdm_capture_ctrl.md
Name: pdm_capture_ctrl

Overview:
- Sequences a PDM microphone deserializer for one recording session: enables it, discards warm-up samples, then writes captured samples to a sample RAM through a simple write port.
- Sits between the microphone deserializer (enable, data, data-ready) and a block-RAM/BRAM-controller write port.
- Software or a top-level FSM drives it with start/stop pulses and reads status back.
- Supports one-shot capture of DEPTH samples and circular (ring-buffer) capture until stopped.

Parameters:
- DATA_WIDTH, 16, sample width; matches deserializer output.
- ADDR_WIDTH, 12, sample RAM address width.
- DEPTH, 4096, samples per buffer; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- WARMUP_SAMPLES, 1024, samples discarded after enable (mic start-up); 0 = no warm-up.

Ports:
- HCLK  in  1  system clock.
- HRESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a session.
- stop  in  1  one-cycle pulse; ends a session.
- circular  in  1  1 = ring-buffer mode; sampled only on an accepted start.
- mic_en  out  1  enable to the deserializer.
- mic_data_ready  in  1  deserializer data-ready; may stay high for several cycles per sample.
- mic_data  in  DATA_WIDTH  deserializer sample.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  DATA_WIDTH  write data.
- busy  out  1  high in WARMUP or CAPTURE.
- done  out  1  level; session finished.
- wrapped  out  1  circular mode has wrapped at least once.
- sample_count  out  ADDR_WIDTH+1  samples written this session; saturates at DEPTH.

Behaviour:
- Reset (HRESET=1 at a rising HCLK edge):
  - State = IDLE.
  - mic_en, mem_we, busy, done and wrapped = 0.
  - mem_addr, mem_wdata and sample_count = 0.
  - The edge-detect register is cleared.
  - Reset mid-session aborts at once; no further writes.
- Sample event:
  - A sample is accepted when mic_data_ready=1 this cycle and was 0 the previous cycle (rising-edge detect).
  - A level held high is one sample.
  - The edge-detect register is forced to 0 whenever mic_en=0.
- States:
  - IDLE: mic_en=0. On start, latch circular, clear done, wrapped, sample_count and the warm-up counter, set mic_en=1, then:
    - go to WARMUP if WARMUP_SAMPLES>0;
    - otherwise go to CAPTURE.
  - WARMUP: mic_en=1, busy=1. Each sample event increments the warm-up counter. The WARMUP_SAMPLES-th event moves to CAPTURE; that sample is discarded.
  - CAPTURE: mic_en=1, busy=1. On each sample event:
    - register mem_wdata<=mic_data;
    - assert mem_we for exactly the next cycle at the current write address;
    - the address then advances.
  - Address wrap:
    - Write address runs 0..DEPTH-1. mem_addr holds the address of the write in progress.
    - circular=0: the DEPTH-th write moves to DONE in the same cycle mem_we is asserted.
    - circular=1: the address wraps to 0 after DEPTH-1, wrapped is set, and capture continues.
  - DONE: mic_en=0, busy=0, done=1 (held). start begins a new session exactly as from IDLE.
- Latency: sample event at edge N gives mem_we=1 during the cycle after edge N, with data sampled at edge N.
- Boundary rules:
  - stop in WARMUP or CAPTURE goes to DONE next edge. A sample event in the same cycle as stop is discarded. A write already strobed completes.
  - stop in IDLE or DONE is ignored.
  - start while busy is ignored.
  - start and stop together in IDLE/DONE: start wins.
  - start and stop together while busy: stop wins.
  - sample_count increments with each mem_we and saturates at DEPTH in circular mode.
  - mem_addr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
- Macro: PDM_CAPTURE_PEAK_EN.
- When defined, add output port peak (DATA_WIDTH):
  - peak holds the maximum of the written samples, treated as unsigned;
  - it is cleared to 0 on reset and on each accepted start;
  - it updates in the same cycle as mem_we;
  - it is held in DONE.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Bench params: DEPTH=8, ADDR_WIDTH=3, WARMUP_SAMPLES=2, with data-ready held high 3 cycles per sample.
- One-shot: start with circular=0, feed samples 0x0001..0x000A.
  - 0x0001 and 0x0002 are discarded.
  - 0x0003..0x000A are written at addresses 0..7, one mem_we each.
  - done=1 and sample_count=8.
  - mic_en=0 afterwards.
- Circular: start with circular=1, feed 12 captured samples after warm-up, then stop.
  - Addresses run 0..7 then 0..3.
  - wrapped=1, sample_count=8, done=1.
- Stop mid-capture: stop arrives in the same cycle as the 4th capture event.
  - Exactly 3 writes occur; sample_count=3; done=1 next cycle.
- Held-ready/start-while-busy:
  - data-ready held high 10 cycles gives exactly one write.
  - start pulsed during CAPTURE changes nothing.
- Reset mid-capture: HRESET=1 for 1 cycle after 5 writes.
  - All outputs are 0 and the state is IDLE next cycle.
  - A following start restarts at address 0.
- PDM_CAPTURE_PEAK_EN: captured samples 0x0010, 0x8000, 0x0123 give peak=0x8000. peak=0 after the next start.
